jk_bank_ctrl: RTL and testbench

//  Sequencer owning a bank of WIDTH JK flip-flops (state q, complement qb).

---
 rtl/jk_bank_ctrl.sv | 164 ++++++++++++++++
 tb/tb_jk_bank_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_ctrl.sv
// jk_bank_ctrl: command sequencer driving a bank of WIDTH JK flip-flops (load, clear, toggle, step up/down).
// Optional abort input for STEP operations is enabled by defining JK_CTRL_ABORT_EN.
module jk_bank_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
`ifdef JK_CTRL_ABORT_EN
    input  logic             abort,
`endif
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RUN,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP       = 3'd0,
        OP_LOAD      = 3'd1,
        OP_CLEAR     = 3'd2,
        OP_TOGGLE    = 3'd3,
        OP_STEP_UP   = 3'd4,
        OP_STEP_DOWN = 3'd5,
        OP_RSV6      = 3'd6,
        OP_RSV7      = 3'd7
    } op_t;

    state_t             state_q, state_d;
    op_t                op_q, op_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   bank_q, bank_d;
    logic               ready_q, busy_q, done_q;
    logic [WIDTH-1:0]   j_drv, k_drv;
    logic [WIDTH-1:0]   up_t, dn_t;
    logic               accept;
    logic               abort_act;
    op_t                cmd_op_e;

`ifdef JK_CTRL_ABORT_EN
    assign abort_act = abort;
`else
    assign abort_act = 1'b0;
`endif

    assign cmd_op_e = op_t'(cmd_op);
    assign accept   = cmd_valid && ready_q;

    // Bit i toggles when all lower bits are 1 (up) or all lower bits are 0 (down).
    always_comb begin
        up_t = '0;
        dn_t = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            logic [WIDTH-1:0] low_mask;
            low_mask = {WIDTH{1'b1}} >> (WIDTH - i);
            up_t[i]  = ((bank_q & low_mask) == low_mask);
            dn_t[i]  = ((bank_q & low_mask) == '0);
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        j_drv   = '0;
        k_drv   = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d   = cmd_op_e;
                    data_d = cmd_data;
                    cnt_d  = cmd_count;
                    if (cmd_op_e == OP_STEP_UP || cmd_op_e == OP_STEP_DOWN) begin
                        state_d = (cmd_count != '0) ? ST_RUN : ST_DONE;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                case (op_q)
                    OP_LOAD: begin
                        j_drv = data_q;
                        k_drv = ~data_q;
                    end
                    OP_CLEAR: begin
                        k_drv = '1;
                    end
                    OP_TOGGLE: begin
                        j_drv = data_q;
                        k_drv = data_q;
                    end
                    default: ;
                endcase
                state_d = ST_DONE;
            end
            ST_RUN: begin
                j_drv = (op_q == OP_STEP_UP) ? up_t : dn_t;
                k_drv = j_drv;
                cnt_d = cnt_q - CNT_W'(1);
                // The step on this edge is applied even when aborting.
                if (cnt_q == CNT_W'(1) || abort_act) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bank_d = (j_drv & ~bank_q) | (~k_drv & bank_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            data_q  <= '0;
            cnt_q   <= '0;
            bank_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            bank_q  <= bank_d;
            ready_q <= (state_d == ST_IDLE);
            busy_q  <= (state_d == ST_EXEC) || (state_d == ST_RUN);
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign q         = bank_q;
    assign qb        = ~bank_q;
    assign j_out     = j_drv;
    assign k_out     = k_drv;

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Directed self-checking bench for jk_bank_ctrl (WIDTH=4, CNT_W=8).
// Abort scenario is exercised only when JK_CTRL_ABORT_EN is defined.
module tb_jk_bank_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_data;
    logic [7:0] cmd_count;
    logic [3:0] j_out, k_out, q, qb;
    logic       busy, done;
`ifdef JK_CTRL_ABORT_EN
    logic       abort = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jk_bank_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef JK_CTRL_ABORT_EN
        .abort     (abort),
`endif
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_count (cmd_count),
        .j_out     (j_out),
        .k_out     (k_out),
        .q         (q),
        .qb        (qb),
        .busy      (busy),
        .done      (done)
    );

    // Waits (bounded) for cmd_ready, presents the command for one accept edge.
    task automatic send(input logic [2:0] op, input logic [3:0] d, input logic [7:0] c);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_wait_ready: cmd_ready=%b required 1 within 20 cycles", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        cmd_count = c;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = 4'h0;
        cmd_count = 8'd0;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 3'd1;
        cmd_data  = 4'hC;
        cmd_count = 8'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (q !== 4'h0 || qb !== 4'hF) begin
            errors++;
            $display("FAIL reset_q: q=%h qb=%h required q=0 qb=f", q, qb);
        end
        checks++;
        if (cmd_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || j_out !== 4'h0 || k_out !== 4'h0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b busy=%b done=%b j=%h k=%h required all 0",
                     cmd_ready, busy, done, j_out, k_out);
        end
        rst       = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || q !== 4'h0) begin
            errors++;
            $display("FAIL reset_release: ready=%b busy=%b q=%h required ready=1 busy=0 q=0",
                     cmd_ready, busy, q);
        end
    endtask

    task automatic test_load_toggle;
        send(3'd1, 4'hA, 8'd0);
        @(negedge clk);
        checks++;
        if (j_out !== 4'hA || k_out !== 4'h5 || busy !== 1'b1 || cmd_ready !== 1'b0 || q !== 4'h0) begin
            errors++;
            $display("FAIL load_exec: j=%h k=%h busy=%b ready=%b q=%h required j=a k=5 busy=1 ready=0 q=0",
                     j_out, k_out, busy, cmd_ready, q);
        end
        @(negedge clk);
        checks++;
        if (q !== 4'hA || qb !== 4'h5 || done !== 1'b1 || cmd_ready !== 1'b0 || j_out !== 4'h0) begin
            errors++;
            $display("FAIL load_done: q=%h qb=%h done=%b ready=%b j=%h required q=a qb=5 done=1 ready=0 j=0",
                     q, qb, done, cmd_ready, j_out);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_idle: done=%b ready=%b required done=0 ready=1", done, cmd_ready);
        end
        send(3'd3, 4'h3, 8'd0);
        @(negedge clk);
        checks++;
        if (j_out !== 4'h3 || k_out !== 4'h3) begin
            errors++;
            $display("FAIL toggle_exec: j=%h k=%h required j=3 k=3", j_out, k_out);
        end
        @(negedge clk);
        checks++;
        if (q !== 4'h9 || done !== 1'b1) begin
            errors++;
            $display("FAIL toggle_done: q=%h done=%b required q=9 done=1", q, done);
        end
    endtask

    task automatic test_clear_reserved;
        send(3'd2, 4'h7, 8'd0);
        @(negedge clk);
        checks++;
        if (j_out !== 4'h0 || k_out !== 4'hF) begin
            errors++;
            $display("FAIL clear_exec: j=%h k=%h required j=0 k=f", j_out, k_out);
        end
        @(negedge clk);
        checks++;
        if (q !== 4'h0 || done !== 1'b1) begin
            errors++;
            $display("FAIL clear_done: q=%h done=%b required q=0 done=1", q, done);
        end
        send(3'd1, 4'h6, 8'd0);
        send(3'd6, 4'hF, 8'd9);
        @(negedge clk);
        checks++;
        if (j_out !== 4'h0 || k_out !== 4'h0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reserved_exec: j=%h k=%h busy=%b required j=0 k=0 busy=1", j_out, k_out, busy);
        end
        @(negedge clk);
        checks++;
        if (q !== 4'h6 || done !== 1'b1) begin
            errors++;
            $display("FAIL reserved_done: q=%h done=%b required q=6 done=1", q, done);
        end
    endtask

    task automatic test_step_up;
        logic [3:0] exp_seq [5];
        int busy_cnt = 0;
        int done_cnt = 0;
        exp_seq = '{4'hE, 4'hF, 4'h0, 4'h1, 4'h2};
        send(3'd1, 4'hD, 8'd0);
        send(3'd4, 4'h0, 8'd5);
        @(negedge clk);
        checks++;
        if (q !== 4'hD || j_out !== 4'h3 || k_out !== 4'h3) begin
            errors++;
            $display("FAIL stepup_first: q=%h j=%h k=%h required q=d j=3 k=3", q, j_out, k_out);
        end
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) done_cnt++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (q !== exp_seq[i]) begin
                errors++;
                $display("FAIL stepup_seq[%0d]: q=%h required %h", i, q, exp_seq[i]);
            end
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) done_cnt++;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) done_cnt++;
        end
        checks++;
        if (busy_cnt != 5 || done_cnt != 1) begin
            errors++;
            $display("FAIL stepup_counts: busy_cycles=%0d done_pulses=%0d required 5 and 1", busy_cnt, done_cnt);
        end
    endtask

    task automatic test_step_down_zero;
        logic [3:0] exp_seq [3];
        int busy_cnt = 0;
        exp_seq = '{4'h0, 4'hF, 4'hE};
        send(3'd1, 4'h1, 8'd0);
        send(3'd5, 4'h0, 8'd3);
        @(negedge clk);
        checks++;
        if (j_out !== 4'h1 || k_out !== 4'h1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stepdn_first: j=%h k=%h busy=%b required j=1 k=1 busy=1", j_out, k_out, busy);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (q !== exp_seq[i]) begin
                errors++;
                $display("FAIL stepdn_seq[%0d]: q=%h required %h", i, q, exp_seq[i]);
            end
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL stepdn_done: done=%b required 1", done);
        end
        send(3'd4, 4'h0, 8'd0);
        @(negedge clk);
        if (busy === 1'b1) busy_cnt++;
        checks++;
        if (done !== 1'b1 || q !== 4'hE) begin
            errors++;
            $display("FAIL stepzero_done: done=%b q=%h required done=1 q=e", done, q);
        end
        @(negedge clk);
        if (busy === 1'b1) busy_cnt++;
        checks++;
        if (done !== 1'b0 || q !== 4'hE || cmd_ready !== 1'b1 || busy_cnt != 0) begin
            errors++;
            $display("FAIL stepzero_idle: done=%b q=%h ready=%b busy_cycles=%0d required 0 e 1 0",
                     done, q, cmd_ready, busy_cnt);
        end
    endtask

    task automatic test_reset_midrun;
        int done_cnt = 0;
        send(3'd2, 4'h0, 8'd0);
        send(3'd4, 4'h0, 8'd200);
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++;
        if (q !== 4'hA || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrun_q: q=%h busy=%b required q=a busy=1", q, busy);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (q !== 4'h0 || qb !== 4'hF || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset: q=%h qb=%h busy=%b done=%b required 0 f 0 0", q, qb, busy, done);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        checks++;
        if (done_cnt != 0 || cmd_ready !== 1'b1 || q !== 4'h0) begin
            errors++;
            $display("FAIL midrun_after: done_pulses=%0d ready=%b q=%h required 0 1 0", done_cnt, cmd_ready, q);
        end
    endtask

`ifdef JK_CTRL_ABORT_EN
    task automatic test_abort;
        send(3'd2, 4'h0, 8'd0);
        send(3'd4, 4'h0, 8'd20);
        repeat (3) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        checks++;
        if (q !== 4'h4 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_done: q=%h done=%b busy=%b required q=4 done=1 busy=0", q, done, busy);
        end
        send(3'd1, 4'h6, 8'd0);
        repeat (2) @(negedge clk);
        checks++;
        if (q !== 4'h6 || done !== 1'b1) begin
            errors++;
            $display("FAIL abort_next_load: q=%h done=%b required q=6 done=1", q, done);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_toggle();
        test_clear_reserved();
        test_step_up();
        test_step_down_zero();
        test_reset_midrun();
`ifdef JK_CTRL_ABORT_EN
        test_abort();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
